// File: rtl/batcharger_adc_seq_if.sv
// ---------------------------------------------------------------------------
// batcharger_adc_seq_if
//
// Connection between the charger's measurement sequencer and the shared
// 8-bit ADC with its analog input mux.
//
// Signals:
//   adc_sel   [1:0]  mux select (00 voltage, 01 current, 10 temperature)
//   adc_start        one-cycle conversion start pulse
//   adc_done         conversion complete, single-cycle pulse
//   adc_data  [7:0]  conversion result, valid while adc_done is high
//
// Modports:
//   master  - sequencer side (drives select/start, receives done/data)
//   slave   - ADC side (receives select/start, drives done/data)
// ---------------------------------------------------------------------------
interface batcharger_adc_seq_if;
    logic [1:0] adc_sel;
    logic       adc_start;
    logic       adc_done;
    logic [7:0] adc_data;

    modport master (
        output adc_sel,
        output adc_start,
        input  adc_done,
        input  adc_data
    );

    modport slave (
        input  adc_sel,
        input  adc_start,
        output adc_done,
        output adc_data
    );
endinterface

// File: rtl/batcharger_adc_seq.sv
// ---------------------------------------------------------------------------
// batcharger_adc_seq
//
// ADC measurement sequencer for the battery charger. Scans the shared ADC
// over the enabled monitor channels (voltage, current, temperature), keeps
// the latest code of each channel and flags when both voltage and
// temperature readings are valid.
//
// Parameters:
//   SETTLE   cycles the mux select is held before each start (1..15)
//   TIMEOUT  max cycles waiting for adc_done after a start (2..255)
//
// Ports:
//   clk                   sequencer clock
//   rst                   asynchronous active-high reset
//   en                    block enable
//   vmonen/imonen/tmonen  channel scan enables
//   adc                   ADC handshake (master modport of
//                         batcharger_adc_seq_if)
//   vbat/ibat/tbat [7:0]  latest voltage / current / temperature codes
//   vtok                  voltage and temperature readings are valid
//
// Configuration macro:
//   BATCHARGER_ADC_AVG_EN  when defined, every channel visit performs two
//                          back-to-back conversions and stores their
//                          rounded mean; otherwise one conversion is stored
//                          unmodified.
// ---------------------------------------------------------------------------
module batcharger_adc_seq #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        vmonen,
    input  logic                        imonen,
    input  logic                        tmonen,
    batcharger_adc_seq_if.master        adc,
    output logic [7:0]                  vbat,
    output logic [7:0]                  ibat,
    output logic [7:0]                  tbat,
    output logic                        vtok
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SELECT = 3'd1;
    localparam logic [2:0] START  = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] STORE  = 3'd4;

    localparam logic [3:0] SETTLE_LAST  = 4'(SETTLE - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [2:0] state;
    logic [1:0] chan;
    logic [3:0] settle_cnt;
    logic [7:0] wait_cnt;
    logic [7:0] sample;
    logic       v_ok;
    logic       i_ok;
    logic       t_ok;

    logic [2:0] mon;
    logic [2:0] first_pick;
    logic [2:0] next_pick;

`ifdef BATCHARGER_ADC_AVG_EN
    logic       second;
    logic [7:0] first_sample;
    logic [8:0] avg_sum;

    // 9-bit sum keeps the carry; the +1 gives round-half-up after >>1.
    assign avg_sum = {1'b0, first_sample} + {1'b0, adc.adc_data} + 9'd1;
`endif

    // Bit index matches the channel code: 0 voltage, 1 current, 2 temp.
    assign mon = {tmonen, imonen, vmonen};

    // Returns {found, channel}: the first enabled channel among c+1, c+2
    // and c (modulo 3). Starting from c=2 yields the V, I, T priority order.
    function automatic logic [2:0] pick_next(input logic [1:0] c,
                                             input logic [2:0] ens);
        logic [1:0] c1;
        logic [1:0] c2;
        c1 = (c == 2'd2) ? 2'd0 : c + 2'd1;
        c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        if (ens[c1])
            return {1'b1, c1};
        else if (ens[c2])
            return {1'b1, c2};
        else if (ens[c])
            return {1'b1, c};
        else
            return 3'b000;
    endfunction

    assign first_pick = pick_next(2'd2, mon);
    assign next_pick  = pick_next(chan, mon);

    // The select register only changes on SELECT entry, so the mux input is
    // stable for the whole settle/convert/store window.
    assign adc.adc_sel   = chan;
    assign adc.adc_start = (state == START);
    assign vtok          = v_ok & t_ok;

    // Sequencer. Dropping en overrides every state: back to IDLE, flags
    // cleared, result registers untouched. adc_done is only looked at in
    // WAIT, so stray pulses elsewhere have no effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            chan       <= 2'd0;
            settle_cnt <= 4'd0;
            wait_cnt   <= 8'd0;
            sample     <= 8'd0;
            v_ok       <= 1'b0;
            i_ok       <= 1'b0;
            t_ok       <= 1'b0;
            vbat       <= 8'd0;
            ibat       <= 8'd0;
            tbat       <= 8'd0;
`ifdef BATCHARGER_ADC_AVG_EN
            second       <= 1'b0;
            first_sample <= 8'd0;
`endif
        end else if (!en) begin
            state      <= IDLE;
            settle_cnt <= 4'd0;
            wait_cnt   <= 8'd0;
            v_ok       <= 1'b0;
            i_ok       <= 1'b0;
            t_ok       <= 1'b0;
`ifdef BATCHARGER_ADC_AVG_EN
            second     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (first_pick[2]) begin
                        chan       <= first_pick[1:0];
                        settle_cnt <= 4'd0;
                        state      <= SELECT;
                    end
                end

                SELECT: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= 4'd0;
                        state      <= START;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end

                START: begin
                    wait_cnt <= 8'd0;
                    state    <= WAIT;
                end

                WAIT: begin
                    if (adc.adc_done) begin
                        wait_cnt <= 8'd0;
`ifdef BATCHARGER_ADC_AVG_EN
                        // First result is parked and a second start is
                        // issued straight away without re-settling.
                        if (!second) begin
                            first_sample <= adc.adc_data;
                            second       <= 1'b1;
                            state        <= START;
                        end else begin
                            sample <= avg_sum[8:1];
                            second <= 1'b0;
                            state  <= STORE;
                        end
`else
                        sample <= adc.adc_data;
                        state  <= STORE;
`endif
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        // A dead ADC invalidates everything; keep scanning
                        // so the readings recover once it answers again.
                        wait_cnt <= 8'd0;
                        v_ok     <= 1'b0;
                        i_ok     <= 1'b0;
                        t_ok     <= 1'b0;
`ifdef BATCHARGER_ADC_AVG_EN
                        second   <= 1'b0;
`endif
                        if (next_pick[2]) begin
                            chan  <= next_pick[1:0];
                            state <= SELECT;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                STORE: begin
                    // The visit completes even if its enable dropped
                    // meanwhile; enables only steer the next choice.
                    case (chan)
                        2'd0: begin
                            vbat <= sample;
                            v_ok <= 1'b1;
                        end
                        2'd1: begin
                            ibat <= sample;
                            i_ok <= 1'b1;
                        end
                        default: begin
                            tbat <= sample;
                            t_ok <= 1'b1;
                        end
                    endcase
                    if (next_pick[2]) begin
                        chan  <= next_pick[1:0];
                        state <= SELECT;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_batcharger_adc_seq.sv
// ---------------------------------------------------------------------------
// tb_batcharger_adc_seq
//
// Directed bench for batcharger_adc_seq with SETTLE=4 and TIMEOUT=64.
// A small ADC model answers each start after a programmable delay with a
// per-channel value latched at the start. Scenario tasks run in sequence
// from one initial block; each checks its own expected values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_batcharger_adc_seq;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;
    // Start-to-start spacing with a 3-cycle ADC: SETTLE + START + 3 + STORE
    localparam int SPACING = SETTLE + 1 + 3 + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       vmonen = 1'b0;
    logic       imonen = 1'b0;
    logic       tmonen = 1'b0;
    logic [7:0] vbat;
    logic [7:0] ibat;
    logic [7:0] tbat;
    logic       vtok;

    batcharger_adc_seq_if adc_bus ();

    batcharger_adc_seq #(
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .vmonen (vmonen),
        .imonen (imonen),
        .tmonen (tmonen),
        .adc    (adc_bus.master),
        .vbat   (vbat),
        .ibat   (ibat),
        .tbat   (tbat),
        .vtok   (vtok)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ADC model controls
    logic [7:0] vals [4];
    bit         resp_on = 1'b1;
    int         resp_delay = 3;
    int         pulse_req = 0;
    logic [7:0] pulse_data = 8'h00;

    // ADC model: answers a start with adc_done on the resp_delay-th cycle
    // after it; an explicit pulse request forces a stray done.
    initial begin : adc_model
        bit         pending;
        int         cnt;
        int         pulse_seen;
        logic [7:0] latched;
        pending    = 1'b0;
        cnt        = 0;
        pulse_seen = 0;
        latched    = 8'h00;
        adc_bus.adc_done = 1'b0;
        adc_bus.adc_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            adc_bus.adc_done = 1'b0;
            if (pulse_req != pulse_seen) begin
                pulse_seen       = pulse_req;
                adc_bus.adc_done = 1'b1;
                adc_bus.adc_data = pulse_data;
            end else if (pending) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    adc_bus.adc_done = 1'b1;
                    adc_bus.adc_data = latched;
                    pending          = 1'b0;
                end
            end else if (adc_bus.adc_start && resp_on) begin
                pending = 1'b1;
                cnt     = resp_delay;
                latched = vals[adc_bus.adc_sel];
            end
        end
    end

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until adc_start is seen or the cycle budget runs out
    task automatic wait_start(input int limit, output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (adc_bus.adc_start === 1'b1) begin
                t  = cyc;
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic applyStimulus(input logic e, input logic v,
                                 input logic i, input logic t);
        en     = e;
        vmonen = v;
        imonen = i;
        tmonen = t;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        checks++;
        if ({vbat, ibat, tbat} !== 24'h0) begin
            errors++;
            $display("[TB] FAIL reset_regs: got %h required 000000", {vbat, ibat, tbat});
        end
        checks++;
        if ({vtok, adc_bus.adc_start, adc_bus.adc_sel} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ctl: got %b required 0000",
                     {vtok, adc_bus.adc_start, adc_bus.adc_sel});
        end
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (adc_bus.adc_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_no_start: got %b required 0", adc_bus.adc_start);
        end
    endtask

    task automatic test_full_scan();
        logic [1:0] exp_sel [4];
        logic [7:0] exp_val [4];
        int         t;
        int         prev;
        bit         ok;
        logic [7:0] got;
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd0};
        exp_val = '{8'hC0, 8'h20, 8'h50, 8'hC0};
        vals = '{8'hC0, 8'h20, 8'h50, 8'h00};
        resp_on = 1'b1;
        prev = 0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            wait_start(40, t, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL scan_start%0d: no adc_start within 40 cycles", k);
                return;
            end
            checks++;
            if (adc_bus.adc_sel !== exp_sel[k]) begin
                errors++;
                $display("[TB] FAIL scan_sel%0d: got %b required %b", k, adc_bus.adc_sel, exp_sel[k]);
            end
            if (k > 0) begin
                checks++;
                if (t - prev != SPACING) begin
                    errors++;
                    $display("[TB] FAIL scan_spacing%0d: got %0d required %0d", k, t - prev, SPACING);
                end
            end
            prev = t;
            repeat (4) tick();
            if (k == 2) begin
                checks++;
                if (vtok !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL vtok_in_store: got %b required 0", vtok);
                end
            end
            tick();
            got = (exp_sel[k] == 2'd0) ? vbat : (exp_sel[k] == 2'd1) ? ibat : tbat;
            checks++;
            if (got !== exp_val[k]) begin
                errors++;
                $display("[TB] FAIL scan_val%0d: got %h required %h", k, got, exp_val[k]);
            end
            checks++;
            if (vtok !== (k >= 2)) begin
                errors++;
                $display("[TB] FAIL scan_vtok%0d: got %b required %b", k, vtok, k >= 2);
            end
        end
    endtask

    task automatic test_voltage_only();
        int t;
        int prev;
        bit ok;
        // Scan is now settling on current; that visit must still finish.
        vals = '{8'h33, 8'h21, 8'h77, 8'h00};
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        wait_start(20, t, ok);
        checks++;
        if (!ok || adc_bus.adc_sel !== 2'd1) begin
            errors++;
            $display("[TB] FAIL vonly_pending_i: ok %b sel %b required sel 01", ok, adc_bus.adc_sel);
        end
        prev = t;
        repeat (5) tick();
        checks++;
        if (ibat !== 8'h21) begin
            errors++;
            $display("[TB] FAIL vonly_i_completes: got %h required 21", ibat);
        end
        for (int k = 0; k < 3; k++) begin
            wait_start(20, t, ok);
            checks++;
            if (!ok || adc_bus.adc_sel !== 2'd0 || t - prev != SPACING) begin
                errors++;
                $display("[TB] FAIL vonly_start%0d: ok %b sel %b spacing %0d required sel 00 spacing %0d",
                         k, ok, adc_bus.adc_sel, t - prev, SPACING);
            end
            prev = t;
            repeat (5) tick();
            checks++;
            if ({vbat, tbat, vtok} !== {8'h33, 8'h50, 1'b1}) begin
                errors++;
                $display("[TB] FAIL vonly_regs%0d: got vbat %h tbat %h vtok %b required 33 50 1",
                         k, vbat, tbat, vtok);
            end
        end
    endtask

    task automatic test_timeout();
        int s;
        int t;
        bit ok;
        // Currently settling on voltage; this visit gets no answer.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        resp_on = 1'b0;
        wait_start(20, s, ok);
        checks++;
        if (!ok || adc_bus.adc_sel !== 2'd0) begin
            errors++;
            $display("[TB] FAIL to_start: ok %b sel %b required sel 00", ok, adc_bus.adc_sel);
            return;
        end
        repeat (TIMEOUT) tick();
        checks++;
        if (vtok !== 1'b1) begin
            errors++;
            $display("[TB] FAIL to_vtok_before: got %b required 1", vtok);
        end
        tick();
        checks++;
        if (vtok !== 1'b0) begin
            errors++;
            $display("[TB] FAIL to_vtok_after: got %b required 0", vtok);
        end
        vals = '{8'h44, 8'h00, 8'h66, 8'h00};
        resp_on = 1'b1;
        wait_start(20, t, ok);
        checks++;
        if (!ok || adc_bus.adc_sel !== 2'd2 || t - s != TIMEOUT + 1 + SETTLE) begin
            errors++;
            $display("[TB] FAIL to_next_chan: ok %b sel %b delay %0d required sel 10 delay %0d",
                     ok, adc_bus.adc_sel, t - s, TIMEOUT + 1 + SETTLE);
        end
        repeat (5) tick();
        checks++;
        if ({tbat, vtok} !== {8'h66, 1'b0}) begin
            errors++;
            $display("[TB] FAIL to_t_only: got tbat %h vtok %b required 66 0", tbat, vtok);
        end
        wait_start(20, t, ok);
        repeat (4) tick();
        checks++;
        if (vtok !== 1'b0) begin
            errors++;
            $display("[TB] FAIL to_vtok_store: got %b required 0", vtok);
        end
        tick();
        checks++;
        if ({vbat, vtok} !== {8'h44, 1'b1}) begin
            errors++;
            $display("[TB] FAIL to_recover: got vbat %h vtok %b required 44 1", vbat, vtok);
        end
    endtask

    task automatic test_en_drop();
        int  s;
        int  e;
        bit  ok;
        bit  saw_start;
        resp_on = 1'b0;
        wait_start(20, s, ok);
        repeat (2) tick();
        en = 1'b0;
        tick();
        checks++;
        if ({vtok, adc_bus.adc_start} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL endrop_ctl: got vtok %b start %b required 0 0", vtok, adc_bus.adc_start);
        end
        pulse_data = 8'hEE;
        pulse_req  = pulse_req + 1;
        saw_start  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (adc_bus.adc_start !== 1'b0) saw_start = 1'b1;
        end
        checks++;
        if (saw_start) begin
            errors++;
            $display("[TB] FAIL endrop_no_start: got start 1 required 0");
        end
        checks++;
        if ({vbat, ibat, tbat, vtok} !== {8'h44, 8'h21, 8'h66, 1'b0}) begin
            errors++;
            $display("[TB] FAIL endrop_regs: got %h %h %h vtok %b required 44 21 66 0",
                     vbat, ibat, tbat, vtok);
        end
        vals = '{8'h12, 8'h00, 8'h9A, 8'h00};
        resp_on = 1'b1;
        en = 1'b1;
        e  = cyc;
        wait_start(20, s, ok);
        checks++;
        if (!ok || adc_bus.adc_sel !== 2'd0 || s - e != SETTLE + 1) begin
            errors++;
            $display("[TB] FAIL endrop_restart: ok %b sel %b delay %0d required sel 00 delay %0d",
                     ok, adc_bus.adc_sel, s - e, SETTLE + 1);
        end
    endtask

    task automatic test_reset_mid_conversion();
        int s;
        int r;
        bit ok;
        bit found;
        found = 1'b0;
        for (int k = 0; k < 3 && !found; k++) begin
            wait_start(20, s, ok);
            if (ok && adc_bus.adc_sel == 2'd2) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL rstmid_find_t: no temperature start seen");
            return;
        end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({vbat, ibat, tbat, vtok, adc_bus.adc_start, adc_bus.adc_sel} !== 28'h0) begin
            errors++;
            $display("[TB] FAIL rstmid_async: got %h %h %h vtok %b start %b sel %b required all 0",
                     vbat, ibat, tbat, vtok, adc_bus.adc_start, adc_bus.adc_sel);
        end
        repeat (3) tick();
        rst = 1'b0;
        r = cyc;
        wait_start(20, s, ok);
        checks++;
        if (!ok || adc_bus.adc_sel !== 2'd0 || s - r != SETTLE + 1) begin
            errors++;
            $display("[TB] FAIL rstmid_restart: ok %b sel %b delay %0d required sel 00 delay %0d",
                     ok, adc_bus.adc_sel, s - r, SETTLE + 1);
        end
    endtask

`ifdef BATCHARGER_ADC_AVG_EN
    task automatic test_avg();
        int s;
        bit ok;
        vals = '{8'h81, 8'h00, 8'h00, 8'h00};
        resp_on = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        wait_start(20, s, ok);
        checks++;
        if (!ok || adc_bus.adc_sel !== 2'd0) begin
            errors++;
            $display("[TB] FAIL avg_first_start: ok %b sel %b", ok, adc_bus.adc_sel);
            return;
        end
        tick();
        vals[0] = 8'h82;
        repeat (3) tick();
        checks++;
        if (adc_bus.adc_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL avg_second_start: got %b required 1", adc_bus.adc_start);
        end
        repeat (5) tick();
        checks++;
        if (vbat !== 8'h82) begin
            errors++;
            $display("[TB] FAIL avg_value: got %h required 82", vbat);
        end
        wait_start(20, s, ok);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({vbat, ibat, tbat, vtok, adc_bus.adc_start, adc_bus.adc_sel} !== 28'h0) begin
            errors++;
            $display("[TB] FAIL avg_rst_async: got vbat %h vtok %b start %b",
                     vbat, vtok, adc_bus.adc_start);
        end
        repeat (2) tick();
        rst = 1'b0;
    endtask
`endif

    initial begin
        vals = '{8'h00, 8'h00, 8'h00, 8'h00};
        test_reset();
`ifdef BATCHARGER_ADC_AVG_EN
        test_avg();
`else
        test_full_scan();
        test_voltage_only();
        test_timeout();
        test_en_drop();
        test_reset_mid_conversion();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case a scenario stalls despite its bounded waits
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/batcharger_adc_seq.md
# batcharger_adc_seq

ADC measurement sequencer for the battery charger. It sits directly upstream of the charger controller: it takes the controller's monitor enables, scans the shared 8-bit ADC over the enabled channels (voltage, current, temperature), and holds the latest `vbat`/`ibat`/`tbat` codes. It asserts `vtok` once valid voltage and temperature readings exist, and drops it on ADC timeout or disable.

## Interface
Parameters:
- `SETTLE`, 4: cycles the mux select is held before each conversion start (1..15).
- `TIMEOUT`, 64: max cycles spent waiting for `adc_done` after a start (2..255).

Ports:
- `clk` input 1: sequencer clock. Single clock domain.
- `rst` input 1: reset, asynchronous and active-high.
- `en` input 1: block enable.
- `vmonen` input 1: scan the voltage channel.
- `imonen` input 1: scan the current channel.
- `tmonen` input 1: scan the temperature channel.
- `adc_done` input 1: ADC conversion complete (single-cycle pulse).
- `adc_data` input 8: ADC result; valid in the cycle `adc_done` is high.
- `adc_sel` output 2: analog mux select. 00 = voltage, 01 = current, 10 = temperature. 11 is never driven.
- `adc_start` output 1: one-cycle conversion start pulse.
- `vbat` output 8: latest voltage code.
- `ibat` output 8: latest current code.
- `tbat` output 8: latest temperature code.
- `vtok` output 1: voltage and temperature readings are valid.

## Operation
- Reset values: `adc_sel`=00, `adc_start`=0, `vbat`/`ibat`/`tbat`=0, `vtok`=0. Internal state: FSM=IDLE, valid flags `v_ok`/`i_ok`/`t_ok`=0, counters=0.
- FSM states: IDLE, SELECT, START, WAIT, STORE.
- IDLE:
  - Stays here while `en`=0 or no monitor enable is set.
  - Otherwise moves to SELECT with the current channel = first enabled channel in order V, I, T.
- SELECT:
  - Drives `adc_sel` for the current channel and counts SETTLE cycles.
  - Then moves to START.
- START:
  - `adc_start`=1 for exactly this one cycle.
  - Then moves to WAIT.
- WAIT:
  - On `adc_done`=1, captures `adc_data` and moves to STORE.
  - If `adc_done` has not arrived after TIMEOUT cycles in WAIT: clear all three valid flags, then go to SELECT for the next channel.
- STORE:
  - Writes the result register of the current channel and sets that channel's valid flag.
  - Selects the next channel: first enabled of (c+1, c+2, c) modulo 3, using the enables sampled in this cycle.
  - Moves to SELECT. If no enable is set, moves to IDLE.
- `vtok` = `v_ok` & `t_ok`, decoded combinationally from the flag registers.
- `i_ok` is internal only.
- `adc_sel` is held constant from SELECT entry through STORE.
- Boundaries:
  - `en` falls in any state: IDLE at the next edge, all valid flags cleared, result registers hold their values.
  - `adc_done` outside WAIT, including the START cycle: ignored.
  - A monitor enable that drops mid-conversion: the conversion completes and is stored.
  - Disabled channels keep their last value and their flag. Example: in charger end-of-charge only voltage is scanned, and `t_ok` stays set.
  - `rst` mid-conversion: immediate return to reset values.

## Timing
- Single conversion, channel switch to stored result: SETTLE + 1 (START) + N (WAIT, where `adc_done` arrives on the N-th WAIT cycle, N≥1) + 1 (STORE) cycles.
- The result register and flag update on the edge that leaves STORE.
- `vtok` reflects the new flags in the following cycle.
- Timeout: the flags clear on the edge ending the TIMEOUT-th WAIT cycle. `vtok`=0 from the next cycle.
- The time from `en` rising to the first `vtok`=1 with V and T enabled is two full conversions, plus averaging if enabled.

## Configuration
- `BATCHARGER_ADC_AVG_EN` defined:
  - Each channel visit performs two back-to-back START/WAIT conversions without re-settling.
  - Stored value = (a + b + 1) >> 1, computed with a 9-bit sum and round-half-up.
  - A timeout on either conversion aborts the visit as above.
- Macro undefined:
  - One conversion per visit.
  - The stored value is `adc_data` unmodified.

## Test plan
- Reset, then `en`=1 with V, I and T all enabled. ADC returns 0xC0/0x20/0x50 with `adc_done` 3 cycles after each start. Expect: `adc_sel` order 00, 01, 10, 00; `vbat`=0xC0, `ibat`=0x20, `tbat`=0x50; `vtok` rises in the cycle after `tbat` is stored; each start is exactly SETTLE+1 cycles after the previous STORE.
- Only `vmonen`=1. Expect: `adc_sel` stays 00, consecutive voltage conversions back-to-back, `tbat` unchanged, `vtok` keeps its prior value.
- Withhold `adc_done` (TIMEOUT=64). Expect: `vtok` falls 64 WAIT cycles after `adc_start`, the sequencer moves to the next channel, and `vtok` re-asserts after fresh V and T results.
- Drop `en` during WAIT, then pulse `adc_done` while in IDLE. Expect: the result registers are not written, `vtok`=0, `adc_start` stays low; on `en`=1 the scan restarts at channel 00.
- With `BATCHARGER_ADC_AVG_EN`, V conversions return 0x81 then 0x82. Expect: `vbat`=0x82 and two `adc_start` pulses per visit. Assert `rst` mid-second conversion: all outputs return to 0 asynchronously.
